multicycle_control_unit: RTL

//  Multicycle MIPS control FSM; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control_unit_pkg.sv | 70 +++++++
 rtl/multicycle_control_unit_if.sv | 39 +++
 rtl/multicycle_control_unit_mem_wait_counter.sv | 31 +++
 rtl/multicycle_control_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - opcode constants for the supported instruction subset
//   - alu_op, alu_src_b and pc_source encodings
//   - FSM state encoding (4-bit binary)
//   - ctrl_t: packed bundle of every per-cycle datapath control
//   - is_mem_state(): states that drive a memory request and wait on rdy
package mips_ctrl_pkg;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] ALU_R      = 6'h00;
    localparam logic [5:0] JUMP       = 6'h02;
    localparam logic [5:0] BRANCH_EQ  = 6'h04;
    localparam logic [5:0] ADDI       = 6'h08;
    localparam logic [5:0] LOAD_WORD  = 6'h23;
    localparam logic [5:0] STORE_WORD = 6'h2B;

    // alu_op classes handed to the ALU control unit
    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_SUB    = 2'd1;
    localparam logic [1:0] ALU_OP_R_TYPE = 2'd2;

    // ALU B operand select
    localparam logic [1:0] ALU_B_REG    = 2'd0;
    localparam logic [1:0] ALU_B_FOUR   = 2'd1;
    localparam logic [1:0] ALU_B_IMM    = 2'd2;
    localparam logic [1:0] ALU_B_IMM_SH = 2'd3;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_R_WB      = 4'd3,
        S_ADDI_EXEC = 4'd4,
        S_ADDI_WB   = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_RD    = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WR    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_2_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and its datapath.
//   master : the control unit  (drives enables/selects, reads opcode + mem_ready)
//   slave  : the datapath side (drives opcode + mem_ready, reads enables/selects)
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_2_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic [1:0]          pc_source;
    logic                illegal_op;
    logic                instr_done;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_done
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_done
    );
endinterface

// File: rtl/multicycle_control_unit_mem_wait_counter.sv
// Fixed-latency memory wait counter used when no ready handshake exists.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart counting (asserted on entry to a memory state)
//   en       : count while sitting in a memory state
//   done     : access complete this cycle (count == MEM_LAT-1)
module mem_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam logic [3:0] TARGET = 4'(MEM_LAT - 1);

    logic [3:0] count_q;

    // Stops at the target (and can never pass 4'hF), so a long stay in a
    // state cannot wrap the count back through the target.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= 4'd0;
        end else if (en && !done && (count_q != 4'hF)) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign done = (count_q == TARGET);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables each cycle.
//   clk, rst : clock, synchronous active-high reset (outputs forced low while high)
//   bus      : master side of multicycle_control_unit_if
//              in : opcode (sampled in DECODE), mem_ready
//              out: pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
//                   ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a,
//                   alu_src_b, alu_op, pc_source, illegal_op, instr_done
// USE_READY=1 waits on mem_ready; USE_READY=0 uses a MEM_LAT-cycle counter.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int ALUOP_W   = 2,
    parameter int USE_READY = 1,
    parameter int MEM_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    multicycle_control_unit_if.master    bus
);
    localparam logic [OPCODE_W-1:0] OPC_R  = OPCODE_W'(ALU_R);
    localparam logic [OPCODE_W-1:0] OPC_J  = OPCODE_W'(JUMP);
    localparam logic [OPCODE_W-1:0] OPC_BEQ = OPCODE_W'(BRANCH_EQ);
    localparam logic [OPCODE_W-1:0] OPC_ADDI = OPCODE_W'(ADDI);
    localparam logic [OPCODE_W-1:0] OPC_LW = OPCODE_W'(LOAD_WORD);
    localparam logic [OPCODE_W-1:0] OPC_SW = OPCODE_W'(STORE_WORD);

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                rdy;
    ctrl_t               ctrl;

    generate
        if (USE_READY != 0) begin : g_ready
            assign rdy = bus.mem_ready;
        end else begin : g_counter
            logic cnt_clr;
            logic cnt_en;
            // Restart on every entry into a memory state, including
            // FETCH -> FETCH never (that is a stay, not an entry).
            assign cnt_clr = (state_d != state_q) && is_mem_state(state_d);
            assign cnt_en  = is_mem_state(state_q);
            mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
                .clk  (clk),
                .rst  (rst),
                .clr  (cnt_clr),
                .en   (cnt_en),
                .done (rdy)
            );
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                if      (bus.opcode == OPC_R)    state_d = S_R_EXEC;
                else if (bus.opcode == OPC_ADDI) state_d = S_ADDI_EXEC;
                else if (bus.opcode == OPC_LW)   state_d = S_MEM_ADDR;
                else if (bus.opcode == OPC_SW)   state_d = S_MEM_ADDR;
                else if (bus.opcode == OPC_BEQ)  state_d = S_BRANCH;
                else if (bus.opcode == OPC_J)    state_d = S_JUMP;
                else                             state_d = S_FETCH;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            // lw/sw split uses the opcode captured in DECODE, not the live input
            S_MEM_ADDR:  state_d = (op_q == OPC_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (rdy) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR:    if (rdy) state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode capture; data-only register, no reset needed
    always_ff @(posedge clk) begin
        if (state_q == S_DECODE) begin
            op_q <= bus.opcode;
        end
    end

    // Moore decode of the state register; only ir_write/pc_write in FETCH
    // and instr_done in MEM_WR look at rdy. Reset forces everything low in
    // the same cycle so a pending write or retire is dropped immediately.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = rdy;
                ctrl.pc_write  = rdy;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ALU_B_IMM_SH;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.illegal_op = (state_d == S_FETCH);
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_REG;
                ctrl.alu_op    = ALU_OP_R_TYPE;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_2_reg  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = rdy;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALU_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (rst) begin
            ctrl = '0;
        end
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_2_reg     = ctrl.mem_2_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ALUOP_W'(ctrl.alu_op);
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.instr_done    = ctrl.instr_done;

endmodule
